// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit -- iterative RV32M multiply/divide unit for the EX stage.
// Multiplies use one shift-add step per cycle over a 64-bit product;
// divides use one restoring step per cycle on operand magnitudes. The unit
// stalls the front of the pipeline while it computes and pulses
// ResultValidE for one cycle in DONE.
// Optional feature: define MULDIV_EARLY_OUT_EN to finish a multiply with a
// zero operand, or a divide by zero, after a single compute cycle.
module ex_muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        StartD2E,
  input  logic [2:0]  MulDivOpD2E,
  input  logic [31:0] OperandAD2E,
  input  logic [31:0] OperandBD2E,
  input  logic [4:0]  WriteAddressD2E,
  input  logic        FlushE,
  output logic        StallE,
  output logic [31:0] ResultE,
  output logic        ResultValidE,
  output logic [4:0]  ResultAddressE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } stateT;

  stateT       state;
  stateT       nextState;
  logic [4:0]  count;

  // Latched operation.
  logic [2:0]  opReg;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic [4:0]  addrReg;

  // Multiply working set: running product, shifted multiplicand, multiplier.
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [31:0] mplier;

  // Divide working set: partial remainder, dividend/quotient, divisor.
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] divisor;
  logic        negQuo;
  logic        negRem;

  // One-step results and the final value captured on entry to DONE.
  logic [63:0] accNext;
  logic [32:0] shifted;
  logic [31:0] remNext;
  logic [31:0] quoNext;
  logic [31:0] finalResult;

  // Decode of the incoming op used when latching.
  logic        accept;
  logic        aSigned;
  logic        bSigned;
  logic        divSigned;
  logic [63:0] aExt;
  logic [31:0] magA;
  logic [31:0] magB;

  logic        earlyOut;
  logic        lastStep;

  assign accept = (state == IDLE) && StartD2E && !FlushE;

  // MUL, MULH and MULHSU treat rs1 as signed; only MUL and MULH treat rs2 as
  // signed. DIV and REM (funct3 bit 0 clear) are the signed divides.
  assign aSigned   = (MulDivOpD2E[1:0] != 2'b11);
  assign bSigned   = !MulDivOpD2E[1];
  assign divSigned = !MulDivOpD2E[0];
  assign aExt      = {{32{aSigned & OperandAD2E[31]}}, OperandAD2E};
  assign magA      = (divSigned && OperandAD2E[31]) ? (32'd0 - OperandAD2E) : OperandAD2E;
  assign magB      = (divSigned && OperandBD2E[31]) ? (32'd0 - OperandBD2E) : OperandBD2E;

`ifdef MULDIV_EARLY_OUT_EN
  logic earlyReg;

  // Remember at issue whether this op can finish after one compute cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      earlyReg <= 1'b0;
    end else if (accept) begin
      earlyReg <= MulDivOpD2E[2] ? (OperandBD2E == 32'd0)
                                 : ((OperandAD2E == 32'd0) || (OperandBD2E == 32'd0));
    end
  end

  assign earlyOut = earlyReg;
`else
  assign earlyOut = 1'b0;
`endif

  assign lastStep = (count == 5'd31) || earlyOut;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
      state <= nextState;
    end
  end

  // Next-state, stall and result-valid decode.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    nextState    = state;
    StallE       = 1'b0;
    ResultValidE = 1'b0;
    case (state)
      IDLE: begin
        if (StartD2E && !FlushE) begin
          StallE    = 1'b1;
          nextState = MulDivOpD2E[2] ? DIV : MUL;
        end
      end
      MUL, DIV: begin
        StallE = 1'b1;
        if (FlushE) begin
          nextState = IDLE;
        end else if (lastStep) begin
          nextState = DONE;
        end
      end
      DONE: begin
        ResultValidE = 1'b1;
        nextState    = IDLE;
      end
      default: nextState = IDLE;
    endcase
    // The start term is combinational on inputs, so hold it off during reset.
    if (!reset) begin
      StallE = 1'b0;
    end
  end

  // One shift-add and one restoring step, plus sign fix-up of the outcome.
  always_comb begin
    accNext = acc + (mplier[0] ? mcand : 64'd0);
    shifted = {rem, quo[31]};
    if (shifted >= {1'b0, divisor}) begin
      remNext = shifted[31:0] - divisor;
      quoNext = {quo[30:0], 1'b1};
    end else begin
      remNext = shifted[31:0];
      quoNext = {quo[30:0], 1'b0};
    end

    finalResult = 32'd0;
    if (state == MUL) begin
      if (earlyOut) begin
        finalResult = 32'd0;
      end else if (opReg[1:0] == 2'b00) begin
        finalResult = accNext[31:0];
      end else begin
        finalResult = accNext[63:32];
      end
    end else begin
      // Division by zero is defined independently of signedness.
      if (operandB == 32'd0) begin
        finalResult = opReg[1] ? operandA : 32'hFFFF_FFFF;
      end else if (opReg[1]) begin
        finalResult = negRem ? (32'd0 - remNext) : remNext;
      end else begin
        finalResult = negQuo ? (32'd0 - quoNext) : quoNext;
      end
    end
  end

  // Datapath: latch on issue, iterate while computing, capture on entry to DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count          <= 5'd0;
      opReg          <= 3'd0;
      operandA       <= 32'd0;
      operandB       <= 32'd0;
      addrReg        <= 5'd0;
      acc            <= 64'd0;
      mcand          <= 64'd0;
      mplier         <= 32'd0;
      rem            <= 32'd0;
      quo            <= 32'd0;
      divisor        <= 32'd0;
      negQuo         <= 1'b0;
      negRem         <= 1'b0;
      ResultE        <= 32'd0;
      ResultAddressE <= 5'd0;
    end else begin
      if (accept) begin
        count    <= 5'd0;
        opReg    <= MulDivOpD2E;
        operandA <= OperandAD2E;
        operandB <= OperandBD2E;
        addrReg  <= WriteAddressD2E;
        // A negative 33-bit multiplier contributes -A * 2^32 through its sign bit.
        acc      <= (bSigned && OperandBD2E[31]) ? (64'd0 - {OperandAD2E, 32'd0}) : 64'd0;
        mcand    <= aExt;
        mplier   <= OperandBD2E;
        rem      <= 32'd0;
        quo      <= magA;
        divisor  <= magB;
        negQuo   <= divSigned && (OperandAD2E[31] ^ OperandBD2E[31]);
        negRem   <= divSigned && OperandAD2E[31];
      end else if ((state == MUL) || (state == DIV)) begin
        count  <= count + 5'd1;
        acc    <= accNext;
        mcand  <= {mcand[62:0], 1'b0};
        mplier <= {1'b0, mplier[31:1]};
        rem    <= remNext;
        quo    <= quoNext;
        if (!FlushE && lastStep) begin
          ResultE        <= finalResult;
          ResultAddressE <= addrReg;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit -- scoreboard bench for ex_muldiv_unit. Directed corner
// cases plus randomized ops; expected results come from a plain-arithmetic
// RV32M model, expected timing from the fixed/early-out latency rule.
// Honors MULDIV_EARLY_OUT_EN the same way as the design.
module tb_ex_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        StartD2E;
  logic [2:0]  MulDivOpD2E;
  logic [31:0] OperandAD2E;
  logic [31:0] OperandBD2E;
  logic [4:0]  WriteAddressD2E;
  logic        FlushE;
  logic        StallE;
  logic [31:0] ResultE;
  logic        ResultValidE;
  logic [4:0]  ResultAddressE;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  addr;
    int          due;
  } expT;

  expT sb[$];
  int  cycleCnt = 0;
  int  total = 0;
  int  bad = 0;

  ex_muldiv_unit dut (
    .clk            (clk),
    .reset          (reset),
    .StartD2E       (StartD2E),
    .MulDivOpD2E    (MulDivOpD2E),
    .OperandAD2E    (OperandAD2E),
    .OperandBD2E    (OperandBD2E),
    .WriteAddressD2E(WriteAddressD2E),
    .FlushE         (FlushE),
    .StallE         (StallE),
    .ResultE        (ResultE),
    .ResultValidE   (ResultValidE),
    .ResultAddressE (ResultAddressE)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  // RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb2, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ia  = a;
    ib  = b;
    case (op)
      3'd0: begin p = sa * sb2; return p[31:0];  end
      3'd1: begin p = sa * sb2; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latOf(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (op[2] ? (b == 0) : (a == 0 || b == 0)) return 2;
`endif
    return 33;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 9))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd1;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Inputs while busy must be ignored, so fill them with noise.
  task automatic junk();
    StartD2E        = 1'($urandom_range(0, 1));
    MulDivOpD2E     = 3'($urandom);
    OperandAD2E     = $urandom;
    OperandBD2E     = $urandom;
    WriteAddressD2E = 5'($urandom);
  endtask

  task automatic sendOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expRes, input bit push);
    expT e;
    logic [4:0] addr;
    addr            = 5'($urandom);
    StartD2E        = 1'b1;
    FlushE          = 1'b0;
    MulDivOpD2E     = op;
    OperandAD2E     = a;
    OperandBD2E     = b;
    WriteAddressD2E = addr;
    if (push) begin
      e.res  = expRes;
      e.addr = addr;
      e.due  = cycleCnt + latOf(op, a, b);
      sb.push_back(e);
    end
  endtask

  task automatic busyWait(input int lat);
    @(negedge clk);
    check("stall_issue", {31'd0, StallE}, 32'd1);
    for (int k = 1; k < lat; k++) begin
      nextCycle();
      junk();
      @(negedge clk);
      check("stall_busy", {31'd0, StallE}, 32'd1);
    end
    nextCycle();
    junk();
    @(negedge clk);
    check("stall_done", {31'd0, StallE}, 32'd0);
  endtask

  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expRes);
    nextCycle();
    sendOp(op, a, b, expRes, 1'b1);
    busyWait(latOf(op, a, b));
  endtask

  // Monitor: pop and compare whenever the DUT presents a result.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (ResultValidE) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", {31'd0, ResultValidE}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("result", ResultE, e.res);
          check("result_addr", {27'd0, ResultAddressE}, {27'd0, e.addr});
          check("latency_cycle", cycleCnt, e.due);
        end
      end else if (sb.size() > 0 && cycleCnt > sb[0].due) begin
        check("valid_by_due", {31'd0, ResultValidE}, 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired at cycle %0d", cycleCnt);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    reset           = 1'b0;
    StartD2E        = 1'b0;
    FlushE          = 1'b0;
    MulDivOpD2E     = 3'd0;
    OperandAD2E     = 32'd0;
    OperandBD2E     = 32'd0;
    WriteAddressD2E = 5'd0;
    repeat (3) nextCycle();
    check("rst_stall", {31'd0, StallE}, 32'd0);
    check("rst_result", ResultE, 32'd0);
    check("rst_valid", {31'd0, ResultValidE}, 32'd0);
    check("rst_addr", {27'd0, ResultAddressE}, 32'd0);
    reset = 1'b1;

    // Directed corner cases.
    runOp(3'd0, 32'd7, 32'd6, 32'h0000_002A);
    check("result_held", ResultE, 32'h0000_002A);

    // Reset mid-operation: outputs clear without an edge, next start accepted.
    nextCycle();
    sendOp(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b0);
    @(negedge clk);
    for (int k = 1; k < 5; k++) begin
      nextCycle();
      junk();
    end
    nextCycle();
    StartD2E = 1'b0;
    reset    = 1'b0;
    #1;
    check("async_rst_stall", {31'd0, StallE}, 32'd0);
    check("async_rst_result", ResultE, 32'd0);
    check("async_rst_valid", {31'd0, ResultValidE}, 32'd0);
    check("async_rst_addr", {27'd0, ResultAddressE}, 32'd0);
    nextCycle();
    nextCycle();
    reset = 1'b1;
    runOp(3'd5, 32'd100, 32'd7, 32'd14);

    runOp(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    runOp(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    runOp(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    runOp(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    runOp(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    runOp(3'd5, 32'hFFFF_FFFE, 32'd2, 32'h7FFF_FFFF);
    runOp(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
    runOp(3'd7, 32'd5, 32'd0, 32'd5);
    runOp(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    runOp(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    runOp(3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
    runOp(3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
    runOp(3'd0, 32'd0, 32'd12345, 32'd0);
    runOp(3'd1, 32'hFFFF_FFFF, 32'd0, 32'd0);

    // Flush in MUL at N+10: no result, idle in N+11, new start accepted.
    nextCycle();
    sendOp(3'd0, 32'd9, 32'd9, 32'd0, 1'b0);
    @(negedge clk);
    for (int k = 1; k < 10; k++) begin
      nextCycle();
      junk();
      @(negedge clk);
      check("stall_pre_flush", {31'd0, StallE}, 32'd1);
    end
    nextCycle();
    junk();
    FlushE = 1'b1;
    @(negedge clk);
    check("stall_flush_cycle", {31'd0, StallE}, 32'd1);
    nextCycle();
    FlushE   = 1'b0;
    StartD2E = 1'b0;
    #1;
    check("stall_after_flush", {31'd0, StallE}, 32'd0);
    sendOp(3'd4, 32'd1000, 32'hFFFF_FFF6, 32'hFFFF_FF9C, 1'b1);
    busyWait(latOf(3'd4, 32'd1000, 32'hFFFF_FFF6));

    // Flush overrides start in IDLE.
    nextCycle();
    StartD2E = 1'b1;
    FlushE   = 1'b1;
    @(negedge clk);
    check("idle_flush_over_start", {31'd0, StallE}, 32'd0);
    nextCycle();
    StartD2E = 1'b0;
    FlushE   = 1'b0;
    @(negedge clk);
    check("idle_stays_idle", {31'd0, StallE}, 32'd0);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom);
      a  = pickOperand();
      b  = pickOperand();
      runOp(op, a, b, refModel(op, a, b));
    end

    nextCycle();
    StartD2E = 1'b0;
    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    repeat (3) nextCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
